// File: rtl/invalid_sum_seq_if.sv
// invalid_sum_seq_if: scan request (start, min, max) and result bundle for invalid_sum_seq.
interface invalid_sum_seq_if #(
  parameter int W = 40,
  parameter int ACC_W = 50,
  parameter int CNT_W = 24
);
  logic start;
  logic [W-1:0] min;
  logic [W-1:0] max;
  logic busy;
  logic done;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] count;
  logic ovf;
  modport master (output start, min, max, input busy, done, sum, count, ovf);
  modport slave (input start, min, max, output busy, done, sum, count, ovf);
endinterface

// File: rtl/invalid_sum_seq.sv
// invalid_sum_seq: sums/counts IDs in [min,max] made of a digit block written twice.
// Optional RANGE_SWAP_EN: bounds are swapped at acceptance when min > max.
module invalid_sum_seq #(
  parameter int W = 40,
  parameter int DIGITS_MAX = 10,
  parameter int ACC_W = 50,
  parameter int CNT_W = 24
) (
  input logic clk,
  input logic rst_n,
  invalid_sum_seq_if.slave bus
);
  localparam int HMAX = DIGITS_MAX / 2;
  localparam int SW = (ACC_W > W ? ACC_W : W) + 1;
  localparam int DCW = $clog2(W);
  typedef enum logic [2:0] {IDLE, SETUP, DIV, STEP, NEXT, DONE} state_t;
  function automatic logic [W-1:0] p10(input int n);
    logic [W-1:0] r;
    r = W'(1);
    for (int k = 0; k < n; k++) r = r * W'(10);
    return r;
  endfunction
  logic [W-1:0] mt [16];
  logic [W-1:0] lot [16];
  logic [W-1:0] hit [16];
  logic [W-1:0] lmt [16];
  for (genvar i = 0; i < 16; i++) begin : g_tab
    assign lot[i] = p10(i - 1);
    assign hit[i] = p10(i) - W'(1);
    assign mt[i] = p10(i) + W'(1);
    assign lmt[i] = p10(i - 1) * (p10(i) + W'(1));
  end
  state_t st;
  logic [3:0] h;
  logic [W-1:0] mn, mx, quo, rem, seed, nrem, nquo, qs;
  logic [W:0] v, t;
  logic [DCW-1:0] dc;
  logic ge, nz;
  logic [SW-1:0] acc;
  always_comb begin
    t = {rem, quo[W-1]};
    ge = t >= {1'b0, mt[h]};
    nrem = W'(ge ? t - {1'b0, mt[h]} : t);
    nquo = {quo[W-2:0], ge};
    nz = |nrem;
    qs = nquo + W'(nz);
    acc = SW'(bus.sum) + SW'(v[W-1:0]);
  end
  // v tracks seed*m incrementally, so no multiplier sits in the candidate loop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      h <= '0;
      mn <= '0;
      mx <= '0;
      quo <= '0;
      rem <= '0;
      seed <= '0;
      v <= '0;
      dc <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum <= '0;
      bus.count <= '0;
      bus.ovf <= 1'b0;
    end else begin
      case (st)
        IDLE: if (bus.start) begin
`ifdef RANGE_SWAP_EN
          mn <= bus.min > bus.max ? bus.max : bus.min;
          mx <= bus.min > bus.max ? bus.min : bus.max;
`else
          mn <= bus.min;
          mx <= bus.max;
`endif
          bus.sum <= '0;
          bus.count <= '0;
          bus.ovf <= 1'b0;
          bus.busy <= 1'b1;
          h <= 4'd1;
          st <= SETUP;
        end
        SETUP: begin
          quo <= mn;
          rem <= '0;
          dc <= '0;
          if (lmt[h] > mx) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            st <= DONE;
          end else st <= DIV;
        end
        DIV: begin
          rem <= nrem;
          quo <= nquo;
          dc <= dc + 1'b1;
          if (dc == DCW'(W - 1)) begin
            seed <= qs < lot[h] ? lot[h] : qs;
            v <= qs < lot[h] ? {1'b0, lmt[h]} : {1'b0, mn} - {1'b0, nrem} + (nz ? {1'b0, mt[h]} : '0);
            st <= STEP;
          end
        end
        STEP: if (seed > hit[h] || v > {1'b0, mx}) st <= NEXT;
        else begin
          bus.sum <= acc[ACC_W-1:0];
          bus.ovf <= bus.ovf | (|acc[SW-1:ACC_W]);
          bus.count <= &bus.count ? bus.count : bus.count + 1'b1;
          seed <= seed + 1'b1;
          v <= v + {1'b0, mt[h]};
        end
        NEXT: if (h == 4'(HMAX)) begin
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          st <= DONE;
        end else begin
          h <= h + 1'b1;
          st <= SETUP;
        end
        DONE: begin
          bus.done <= 1'b0;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_invalid_sum_seq.sv
// tb_invalid_sum_seq: random and directed scans of two invalid_sum_seq configurations
// compared against a closed-form arithmetic-series model.
module tb_invalid_sum_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  invalid_sum_seq_if #(.W(40), .ACC_W(50), .CNT_W(24)) ba ();
  invalid_sum_seq_if #(.W(16), .ACC_W(8), .CNT_W(4)) bs ();
  invalid_sum_seq u_a (.clk(clk), .rst_n(rst_n), .bus(ba));
  invalid_sum_seq #(.W(16), .DIGITS_MAX(4), .ACC_W(8), .CNT_W(4)) u_s (.clk(clk), .rst_n(rst_n), .bus(bs));
  logic sel = 1'b0;
  logic st_d = 1'b0;
  logic [63:0] mn_d = '0;
  logic [63:0] mx_d = '0;
  assign ba.start = st_d & ~sel;
  assign bs.start = st_d & sel;
  assign ba.min = mn_d[39:0];
  assign ba.max = mx_d[39:0];
  assign bs.min = mn_d[15:0];
  assign bs.max = mx_d[15:0];
  logic done_x, busy_x, ovf_x;
  logic [63:0] sum_x, count_x;
  assign done_x = sel ? bs.done : ba.done;
  assign busy_x = sel ? bs.busy : ba.busy;
  assign ovf_x = sel ? bs.ovf : ba.ovf;
  assign sum_x = sel ? 64'(bs.sum) : 64'(ba.sum);
  assign count_x = sel ? 64'(bs.count) : 64'(ba.count);
  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Hits of half-length h are s*(10^h+1) for s in [10^(h-1), 10^h-1]; sum them as a series.
  task automatic model(input longint unsigned a_in, input longint unsigned b_in,
                       output longint unsigned es, output longint unsigned ec, output logic eo, output int lat);
    longint unsigned mn, mx, p, lo, hi, m, a, b, k, tot, n, cmax, tmp;
    int w, hmax, accw;
    bit stop;
    mn = a_in;
    mx = b_in;
    w = sel ? 16 : 40;
    hmax = sel ? 2 : 5;
    accw = sel ? 8 : 50;
    cmax = sel ? 64'd15 : 64'd16777215;
`ifdef RANGE_SWAP_EN
    if (mn > mx) begin
      tmp = mn;
      mn = mx;
      mx = tmp;
    end
`endif
    p = 1;
    tot = 0;
    n = 0;
    lat = 0;
    stop = 0;
    for (int h = 1; h <= hmax && !stop; h++) begin
      lo = p;
      p = p * 10;
      hi = p - 1;
      m = p + 1;
      if (lo * m > mx) begin
        lat++;
        stop = 1;
      end else begin
        a = (mn + m - 1) / m;
        if (a < lo) a = lo;
        b = mx / m;
        if (b > hi) b = hi;
        k = (a <= b) ? b - a + 1 : 0;
        if (k != 0) tot += m * ((a + b) * k / 2);
        n += k;
        lat += w + 3 + int'(k);
      end
    end
    es = tot & ((64'd1 << accw) - 1);
    eo = (tot >> accw) != 0;
    ec = n > cmax ? cmax : n;
  endtask
  task automatic run(input string tag, input logic s, input longint unsigned a, input longint unsigned b, input int poke);
    longint unsigned es, ec;
    logic eo;
    int el, lat;
    @(negedge clk);
    sel = s;
    mn_d = a;
    mx_d = b;
    st_d = 1'b1;
    model(a, b, es, ec, eo, el);
    @(posedge clk);
    #1 st_d = 1'b0;
    check({tag, ".busy_on"}, 64'(busy_x), 64'd1);
    lat = 0;
    while (lat < 20000 && !done_x) begin
      @(posedge clk);
      #1 lat++;
      st_d = (lat == poke);
      if (lat == poke) begin
        mn_d = 95;
        mx_d = 115;
      end
    end
    st_d = 1'b0;
    check({tag, ".lat"}, 64'(lat), 64'(el));
    check({tag, ".done"}, 64'(done_x), 64'd1);
    check({tag, ".busy_off"}, 64'(busy_x), 64'd0);
    check({tag, ".sum"}, sum_x, es);
    check({tag, ".count"}, count_x, ec);
    check({tag, ".ovf"}, 64'(ovf_x), 64'(eo));
    st_d = 1'b1;
    @(posedge clk);
    #1 st_d = 1'b0;
    check({tag, ".ign_busy"}, 64'(busy_x), 64'd0);
    check({tag, ".ign_done"}, 64'(done_x), 64'd0);
    check({tag, ".hold_sum"}, sum_x, es);
  endtask
  initial begin
    longint unsigned a, b, tmp, es, ec;
    logic eo, seen;
    int el;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 64'(ba.busy | bs.busy), 64'd0);
    check("rst.done", 64'(ba.done | bs.done), 64'd0);
    check("rst.sum", 64'(ba.sum) | 64'(bs.sum), 64'd0);
    check("rst.count", 64'(ba.count) | 64'(bs.count), 64'd0);
    check("rst.ovf", 64'(ba.ovf | bs.ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("r11_22", 0, 11, 22, 0);
    run("r95_115", 0, 95, 115, 0);
    run("r998_1012", 0, 998, 1012, 0);
    run("rbig", 0, 64'd1188511880, 64'd1188511890, 0);
    run("r222220", 0, 222220, 222224, 0);
    run("r1_9", 0, 1, 9, 0);
    run("r22_11", 0, 22, 11, 0);
    run("poke", 0, 11, 22, 10);
    run("s11_99", 1, 11, 99, 0);
    run("s_sat", 1, 11, 9999, 0);
    run("s1_9", 1, 1, 9, 0);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 1) begin
        a = {$urandom, $urandom} % 64'd10000000000;
        b = a + 64'($urandom_range(0, 2000000));
      end else begin
        a = 64'($urandom_range(0, 200000));
        b = a + 64'($urandom_range(0, 3000));
      end
      if ($urandom_range(0, 7) == 0) begin
        tmp = a;
        a = b;
        b = tmp;
      end
      run("rnd_a", 0, a, b, 0);
    end
    for (int i = 0; i < 8; i++) run("rnd_s", 1, 64'($urandom_range(0, 9999)), 64'($urandom_range(0, 9999)), 0);
    @(negedge clk);
    sel = 1'b0;
    mn_d = 11;
    mx_d = 1111;
    st_d = 1'b1;
    @(posedge clk);
    #1 st_d = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    model(11, 99, es, ec, eo, el);
    check("rst_mid.pre_sum", sum_x, es);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid.busy", 64'(busy_x), 64'd0);
    check("rst_mid.done", 64'(done_x), 64'd0);
    check("rst_mid.sum", sum_x, 64'd0);
    check("rst_mid.count", count_x, 64'd0);
    check("rst_mid.ovf", 64'(ovf_x), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (300) begin
      @(posedge clk);
      #1 seen = seen | done_x | busy_x;
    end
    check("rst_mid.no_done", 64'(seen), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
